// File: rtl/sobel_gradient_pkg.sv
// sobel_pkg: shared types, constants and kernel helper for the Sobel gradient stage.
//   pixel_t     8-bit unsigned grayscale sample
//   grad_raw_t  11-bit signed raw gradient (range -GRAD_MAX..+GRAD_MAX)
//   column_t    one vertical 3-pixel slice of the window (top/mid/bot)
package sobel_pkg;

  localparam int unsigned PIXEL_W = 8;
  localparam int          GRAD_MAX = 1020;
  // Magnitude bits for GRAD_MAX plus a sign bit; evaluates to 11.
  localparam int unsigned GRAD_RAW_W = $clog2(GRAD_MAX + 1) + 1;

  typedef logic [PIXEL_W-1:0]           pixel_t;
  typedef logic signed [GRAD_RAW_W-1:0] grad_raw_t;

  typedef struct packed {
    pixel_t top;
    pixel_t mid;
    pixel_t bot;
  } column_t;

  // Sobel smoothing weights along the axis orthogonal to the derivative.
  localparam grad_raw_t K_EDGE = grad_raw_t'(1);
  localparam grad_raw_t K_MID  = grad_raw_t'(2);

  // Weighted 1-2-1 sum of three pixels, in raw-gradient precision.
  function automatic grad_raw_t weight_121(pixel_t a, pixel_t b, pixel_t c);
    return (K_EDGE * grad_raw_t'(a)) + (K_MID * grad_raw_t'(b)) + (K_EDGE * grad_raw_t'(c));
  endfunction

endpackage

// File: rtl/sobel_gradient_if.sv
// sobel_gradient_if: pixel stream in, gradient stream out.
//   in_valid/in_pixel/in_sof  raster-order pixel input (in_sof marks (0,0))
//   out_valid/vert_out/horz_out  signed Gy/Gx, PRECISION bits
//   out_x/out_y  centre coordinate, only with SOBEL_GRADIENT_COORD_EN
// Modports: master = pixel source / result sink, slave = the Sobel stage.
interface sobel_gradient_if
  import sobel_pkg::*;
#(
  parameter int unsigned PRECISION = 24
`ifdef SOBEL_GRADIENT_COORD_EN
  , parameter int unsigned WIDTH  = 640
  , parameter int unsigned HEIGHT = 480
`endif
);

  logic                 in_valid;
  pixel_t               in_pixel;
  logic                 in_sof;
  logic                 out_valid;
  logic [PRECISION-1:0] vert_out;
  logic [PRECISION-1:0] horz_out;

`ifdef SOBEL_GRADIENT_COORD_EN
  logic [$clog2(WIDTH)-1:0]  out_x;
  logic [$clog2(HEIGHT)-1:0] out_y;

  modport master (
    output in_valid, in_pixel, in_sof,
    input  out_valid, vert_out, horz_out, out_x, out_y
  );
  modport slave (
    input  in_valid, in_pixel, in_sof,
    output out_valid, vert_out, horz_out, out_x, out_y
  );
`else
  modport master (
    output in_valid, in_pixel, in_sof,
    input  out_valid, vert_out, horz_out
  );
  modport slave (
    input  in_valid, in_pixel, in_sof,
    output out_valid, vert_out, horz_out
  );
`endif

endinterface

// File: rtl/sobel_gradient_line_buffer.sv
// sobel_line_buffer: single-port DEPTH x DATA_W RAM, read-before-write.
//   clk      write clock
//   en       write enable (write wdata at addr on posedge)
//   addr     shared read/write address
//   wdata    write data
//   rdata_c  combinational read of the current (pre-write) contents
// Contents are deliberately not reset.
module sobel_line_buffer #(
  parameter int unsigned DEPTH  = 640,
  parameter int unsigned DATA_W = 8
) (
  input  logic                     clk,
  input  logic                     en,
  input  logic [$clog2(DEPTH)-1:0] addr,
  input  logic [DATA_W-1:0]        wdata,
  output logic [DATA_W-1:0]        rdata_c
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Asynchronous read returns the old word during the write cycle.
  assign rdata_c = mem[addr];

  always_ff @(posedge clk) begin
    if (en) begin
      mem[addr] <= wdata;
    end
  end

endmodule

// File: rtl/sobel_gradient.sv
// sobel_gradient: streaming 3x3 Sobel stage, one pixel per clock, no backpressure.
//   clk    system clock
//   reset  synchronous active-high reset
//   bus    sobel_gradient_if.slave (pixel input, Gy/Gx output)
// Result for centre (x-1,y-1) appears two cycles after the pixel at (x,y), x>=2, y>=2.
// Optional macro SOBEL_GRADIENT_COORD_EN adds registered out_x/out_y centre coordinates.
module sobel_gradient
  import sobel_pkg::*;
#(
  parameter int unsigned WIDTH     = 640,
  parameter int unsigned HEIGHT    = 480,
  parameter int unsigned PRECISION = 24
) (
  input  logic              clk,
  input  logic              reset,
  sobel_gradient_if.slave   bus
);

  localparam int unsigned XW = $clog2(WIDTH);
  localparam int unsigned YW = $clog2(HEIGHT);

  logic          accept;
  logic [XW-1:0] col, cx, col_nxt;
  logic [YW-1:0] row, cy, row_nxt;
  logic [15:0]   lines_rd;
  column_t       new_col;
  column_t       win_l, win_m, win_r;
  logic          win_emit;
  grad_raw_t     gx, gy;

  assign accept = bus.in_valid;

  // Effective position of the incoming pixel (in_sof forces (0,0)) and the position after it.
  always_comb begin
    cx      = col;
    cy      = row;
    col_nxt = col;
    row_nxt = row;
    if (bus.in_valid && bus.in_sof) begin
      cx = '0;
      cy = '0;
    end
    if (cx == XW'(WIDTH - 1)) begin
      col_nxt = '0;
      row_nxt = (cy == YW'(HEIGHT - 1)) ? '0 : cy + YW'(1);
    end else begin
      col_nxt = cx + XW'(1);
      row_nxt = cy;
    end
  end

  // Raster position counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      col <= '0;
      row <= '0;
    end else if (accept) begin
      col <= col_nxt;
      row <= row_nxt;
    end
  end

  // Both line buffers packed in one word: [15:8] row y-2, [7:0] row y-1.
  sobel_line_buffer #(
    .DEPTH  (WIDTH),
    .DATA_W (16)
  ) u_lines (
    .clk     (clk),
    .en      (accept),
    .addr    (cx),
    .wdata   ({lines_rd[7:0], bus.in_pixel}),
    .rdata_c (lines_rd)
  );

  assign new_col = '{top: lines_rd[15:8], mid: lines_rd[7:0], bot: bus.in_pixel};

  // 3x3 window shift register plus emit flag for the centre it now holds.
  always_ff @(posedge clk) begin
    if (reset) begin
      win_l    <= '0;
      win_m    <= '0;
      win_r    <= '0;
      win_emit <= 1'b0;
    end else begin
      win_emit <= accept && (cx >= XW'(2)) && (cy >= YW'(2));
      if (accept) begin
        win_l <= win_m;
        win_m <= win_r;
        win_r <= new_col;
      end
    end
  end

  // Gx: right column minus left column; Gy: bottom row minus top row.
  always_comb begin
    gx = weight_121(win_r.top, win_r.mid, win_r.bot) - weight_121(win_l.top, win_l.mid, win_l.bot);
    gy = weight_121(win_l.bot, win_m.bot, win_r.bot) - weight_121(win_l.top, win_m.top, win_r.top);
  end

  // Output register: gradients update only with a result, otherwise hold.
  always_ff @(posedge clk) begin
    if (reset) begin
      bus.out_valid <= 1'b0;
      bus.vert_out  <= '0;
      bus.horz_out  <= '0;
    end else begin
      bus.out_valid <= win_emit;
      if (win_emit) begin
        bus.vert_out <= PRECISION'(gy);
        bus.horz_out <= PRECISION'(gx);
      end
    end
  end

`ifdef SOBEL_GRADIENT_COORD_EN
  logic [XW-1:0] win_x;
  logic [YW-1:0] win_y;

  // Centre coordinate travels alongside the window and the gradients.
  always_ff @(posedge clk) begin
    if (reset) begin
      win_x     <= '0;
      win_y     <= '0;
      bus.out_x <= '0;
      bus.out_y <= '0;
    end else begin
      if (accept) begin
        win_x <= cx - XW'(1);
        win_y <= cy - YW'(1);
      end
      if (win_emit) begin
        bus.out_x <= win_x;
        bus.out_y <= win_y;
      end
    end
  end
`endif

endmodule

// File: tb/tb_sobel_gradient.sv
// tb_sobel_gradient: randomized and directed stimulus for sobel_gradient, checked against
// a frame-array reference model (kernel evaluated directly on stored pixels).
module tb_sobel_gradient;

  localparam int unsigned WIDTH     = 5;
  localparam int unsigned HEIGHT    = 4;
  localparam int unsigned PRECISION = 24;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  sobel_gradient_if #(
    .PRECISION (PRECISION)
`ifdef SOBEL_GRADIENT_COORD_EN
    , .WIDTH  (WIDTH)
    , .HEIGHT (HEIGHT)
`endif
  ) bus ();

  sobel_gradient #(
    .WIDTH     (WIDTH),
    .HEIGHT    (HEIGHT),
    .PRECISION (PRECISION)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    int     gx;
    int     gy;
    int     x;
    int     y;
    longint due;
  } exp_t;

  int     n_tests = 0;
  int     n_fail  = 0;
  int     n_out   = 0;
  longint cyc     = 0;
  exp_t   q[$];
  int     img[HEIGHT][WIDTH];
  int     mx = 0;
  int     my = 0;
  int     wgt[3] = '{1, 2, 1};

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input longint got, input longint exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Reference: store pixel at its frame position, evaluate the kernel on the stored frame.
  task automatic model_pixel(input int pix, input bit sof);
    exp_t e;
    if (sof) begin
      mx = 0;
      my = 0;
    end
    img[my][mx] = pix;
    if (mx >= 2 && my >= 2) begin
      e.gx = 0;
      e.gy = 0;
      for (int r = 0; r < 3; r++) e.gx += wgt[r] * (img[my-2+r][mx] - img[my-2+r][mx-2]);
      for (int c = 0; c < 3; c++) e.gy += wgt[c] * (img[my][mx-2+c] - img[my-2][mx-2+c]);
      e.x   = mx - 1;
      e.y   = my - 1;
      e.due = cyc + 2;
      q.push_back(e);
    end
    mx++;
    if (mx == WIDTH) begin
      mx = 0;
      my++;
      if (my == HEIGHT) my = 0;
    end
  endtask

  // Result monitor, sampled mid-cycle.
  always @(negedge clk) begin : mon
    exp_t e;
    if (bus.out_valid) begin
      n_out++;
      if (q.size() == 0) begin
        check("spurious_out", 1, 0);
      end else begin
        e = q.pop_front();
        check("horz_out", longint'($signed(bus.horz_out)), e.gx);
        check("vert_out", longint'($signed(bus.vert_out)), e.gy);
        check("latency", cyc, e.due);
`ifdef SOBEL_GRADIENT_COORD_EN
        check("out_x", longint'(bus.out_x), e.x);
        check("out_y", longint'(bus.out_y), e.y);
`endif
      end
    end
  end

  task automatic drive(input int pix, input bit sof);
    model_pixel(pix, sof);
    bus.in_valid = 1'b1;
    bus.in_pixel = 8'(pix);
    bus.in_sof   = sof;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.in_sof   = 1'b0;
  endtask

  task automatic idle(input int n);
    bus.in_valid = 1'b0;
    bus.in_sof   = 1'b0;
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  function automatic int pat(input int kind, input int x, input int y);
    case (kind)
      0:       return 100;
      1:       return (x >= 2) ? 255 : 0;
      default: return (y >= 2) ? 10 : 0;
    endcase
  endfunction

  task automatic send_frame(input int kind, input bit bubbles, input bit sof_first);
    for (int y = 0; y < int'(HEIGHT); y++) begin
      for (int x = 0; x < int'(WIDTH); x++) begin
        drive(pat(kind, x, y), sof_first && x == 0 && y == 0);
        if (bubbles) idle(1);
      end
    end
  endtask

  // Finish a directed case: let results drain, then check count and empty scoreboard.
  task automatic close_case(input string tag, input int start_out, input int exp_count);
    idle(4);
    check({tag, "_count"}, n_out - start_out, exp_count);
    check({tag, "_drain"}, q.size(), 0);
  endtask

  task automatic rand_stream(input int n);
    bit sof;
    for (int i = 0; i < n; i++) begin
      sof = (i == 0) || ($urandom_range(0, 39) == 0);
      drive(int'($urandom_range(0, 255)), sof);
      if ($urandom_range(0, 2) == 0) idle(int'($urandom_range(1, 3)));
    end
  endtask

  initial begin : main
    int start;
    reset        = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_pixel = '0;
    bus.in_sof   = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_out_valid", longint'(bus.out_valid), 0);
    check("reset_vert_out", longint'(bus.vert_out), 0);
    check("reset_horz_out", longint'(bus.horz_out), 0);
    reset = 1'b0;
    idle(1);

    start = n_out; send_frame(0, 1'b0, 1'b1); close_case("flat", start, 6);
    start = n_out; send_frame(1, 1'b0, 1'b1); close_case("vedge", start, 6);
    start = n_out; send_frame(2, 1'b0, 1'b1); close_case("hedge", start, 6);
    start = n_out; send_frame(1, 1'b1, 1'b1); close_case("vedge_bubbles", start, 6);

    // Abandoned partial frame followed by a fresh frame.
    start = n_out;
    for (int i = 0; i < 7; i++) drive(int'($urandom_range(0, 255)), i == 0);
    send_frame(0, 1'b0, 1'b1);
    close_case("abort", start, 6);

    // Reset while two results are in flight; the second one must be dropped.
    for (int i = 0; i < 14; i++) drive(pat(1, i % int'(WIDTH), i / int'(WIDTH)), i == 0);
    reset = 1'b1;
    idle(1);
    q.delete();
    mx = 0;
    my = 0;
    check("midreset_out_valid", longint'(bus.out_valid), 0);
    check("midreset_vert_out", longint'(bus.vert_out), 0);
    check("midreset_horz_out", longint'(bus.horz_out), 0);
    reset = 1'b0;
    start = n_out;
    send_frame(1, 1'b0, 1'b0);
    close_case("after_reset", start, 6);

    for (int k = 0; k < 4; k++) begin
      rand_stream(60);
      idle(4);
      check("rand_drain", q.size(), 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
